// File: rtl/iic_seq_pkg.sv
// Register map, bit constants and state encodings shared by the AXI IIC write sequencer
// and its single-beat AXI-Lite master.
package iic_seq_pkg;

  localparam logic [31:0] CR_OFS      = 32'h0000_0100;
  localparam logic [31:0] SR_OFS      = 32'h0000_0104;
  localparam logic [31:0] TX_FIFO_OFS = 32'h0000_0108;

  localparam logic [31:0] CR_TX_FIFO_RST = 32'h0000_0002;
  localparam logic [31:0] CR_EN          = 32'h0000_0001;
  localparam logic [31:0] TXF_START      = 32'h0000_0100;
  localparam logic [31:0] TXF_STOP       = 32'h0000_0200;

  localparam int SR_BB_BIT       = 2;
  localparam int SR_TX_EMPTY_BIT = 7;

  // Bus idle means TX FIFO empty with the bus-busy flag clear.
  localparam logic [31:0] SR_IDLE_MASK = (32'd1 << SR_TX_EMPTY_BIT) | (32'd1 << SR_BB_BIT);
  localparam logic [31:0] SR_IDLE_VAL  = (32'd1 << SR_TX_EMPTY_BIT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_GAP,
    ST_RD,
    ST_RD_DATA,
    ST_DONE
  } seq_state_e;

  typedef enum logic [2:0] {
    M_IDLE,
    M_WRITE,
    M_BRESP,
    M_READ,
    M_RDATA
  } mst_state_e;

  function automatic logic [31:0] step_offset(input logic [1:0] step);
    logic [31:0] ofs;
    ofs = (step >= 2'd2) ? TX_FIFO_OFS : CR_OFS;
    return ofs;
  endfunction

  function automatic logic [31:0] step_wdata(input logic [1:0] step,
                                             input logic [6:0] dev,
                                             input logic [7:0] data);
    logic [31:0] wd;
    case (step)
      2'd0:    wd = CR_TX_FIFO_RST;
      2'd1:    wd = CR_EN;
      2'd2:    wd = TXF_START | {24'd0, dev, 1'b0};
      default: wd = TXF_STOP | {24'd0, data};
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/axil_single_master.sv
// Issues exactly one AXI4-Lite write or read per accepted command and reports the
// response; AW and W are raised together and retire independently.
module axil_single_master
  import iic_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_is_read,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready
);

  mst_state_e  state_q, state_d;
  logic        aw_pend_q, aw_pend_d;
  logic        w_pend_q, w_pend_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        aw_hs, w_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= M_IDLE;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign cmd_ready = (state_q == M_IDLE);
  assign m_awaddr  = addr_q;
  assign m_araddr  = addr_q;
  assign m_wdata   = wdata_q;
  assign m_awvalid = (state_q == M_WRITE) && aw_pend_q;
  assign m_wvalid  = (state_q == M_WRITE) && w_pend_q;
  assign m_bready  = (state_q == M_BRESP);
  assign m_arvalid = (state_q == M_READ);
  assign m_rready  = (state_q == M_RDATA);
  assign aw_hs     = m_awvalid && m_awready;
  assign w_hs      = m_wvalid && m_wready;
  assign rsp_data  = m_rdata;

  always_comb begin
    state_d   = state_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    case (state_q)
      M_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          if (cmd_is_read) begin
            state_d = M_READ;
          end else begin
            state_d   = M_WRITE;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
          end
        end
      end
      M_WRITE: begin
        if (aw_hs) aw_pend_d = 1'b0;
        if (w_hs)  w_pend_d  = 1'b0;
        // A channel counts as done if it retired earlier or handshakes right now.
        if ((!aw_pend_q || aw_hs) && (!w_pend_q || w_hs)) state_d = M_BRESP;
      end
      M_BRESP: begin
        if (m_bvalid) begin
          rsp_valid = 1'b1;
          rsp_err   = (m_bresp != 2'b00);
          state_d   = M_IDLE;
        end
      end
      M_READ: begin
        if (m_arready) state_d = M_RDATA;
      end
      M_RDATA: begin
        if (m_rvalid) begin
          rsp_valid = 1'b1;
          rsp_err   = (m_rresp != 2'b00);
          state_d   = M_IDLE;
        end
      end
      default: state_d = M_IDLE;
    endcase
  end

endmodule

// File: rtl/iic_axil_sequencer.sv
// Sequences a single-byte I2C write through the AXI IIC register map: FIFO reset,
// enable, START+address, data+STOP, then polls the status register until the bus idles.
module iic_axil_sequencer
  import iic_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h43C0_0000,
  parameter int unsigned POLL_MAX  = 1024,
  parameter int unsigned POLL_GAP  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_dev_addr,
  input  logic [7:0]  req_data,
  output logic        done_valid,
  output logic        done_err,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready
);

  localparam int PC_W = $clog2(POLL_MAX + 1);
  localparam int GC_W = $clog2(POLL_GAP + 1) + 1;

  seq_state_e      state_q, state_d;
  logic [1:0]      step_q, step_d;
  logic [PC_W-1:0] poll_cnt_q, poll_cnt_d;
  logic [GC_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [6:0]      dev_q, dev_d;
  logic [7:0]      data_q, data_d;
  logic            err_q, err_d;

  logic            cmd_valid, cmd_ready, cmd_is_read;
  logic [31:0]     cmd_addr, cmd_wdata;
  logic            rsp_valid, rsp_err;
  logic [31:0]     rsp_data;
  logic [31:0]     poll_next, gap_next;

  axil_single_master u_mst (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_is_read (cmd_is_read),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .m_awaddr    (m_awaddr),
    .m_awvalid   (m_awvalid),
    .m_awready   (m_awready),
    .m_wdata     (m_wdata),
    .m_wvalid    (m_wvalid),
    .m_wready    (m_wready),
    .m_bresp     (m_bresp),
    .m_bvalid    (m_bvalid),
    .m_bready    (m_bready),
    .m_araddr    (m_araddr),
    .m_arvalid   (m_arvalid),
    .m_arready   (m_arready),
    .m_rdata     (m_rdata),
    .m_rresp     (m_rresp),
    .m_rvalid    (m_rvalid),
    .m_rready    (m_rready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
      dev_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      dev_q      <= dev_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign done_valid = (state_q == ST_DONE);
  assign done_err   = (state_q == ST_DONE) && err_q;
  assign poll_next  = 32'(poll_cnt_q) + 32'd1;
  assign gap_next   = 32'(gap_cnt_q) + 32'd1;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    poll_cnt_d  = poll_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    dev_d       = dev_q;
    data_d      = data_q;
    err_d       = err_q;
    cmd_valid   = 1'b0;
    cmd_is_read = 1'b0;
    cmd_addr    = BASE_ADDR + step_offset(step_q);
    cmd_wdata   = step_wdata(step_q, dev_q, data_q);
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          dev_d      = req_dev_addr;
          data_d     = req_data;
          step_d     = 2'd0;
          poll_cnt_d = '0;
          err_d      = 1'b0;
          state_d    = ST_WR;
        end
      end
      ST_WR: begin
        cmd_valid = 1'b1;
        if (cmd_ready) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (rsp_valid) begin
          if (rsp_err) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (step_q == 2'd3) begin
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end else begin
            step_d  = step_q + 2'd1;
            state_d = ST_WR;
          end
        end
      end
      ST_GAP: begin
        if (gap_next >= POLL_GAP) state_d = ST_RD;
        else gap_cnt_d = gap_cnt_q + GC_W'(1);
      end
      ST_RD: begin
        cmd_valid   = 1'b1;
        cmd_is_read = 1'b1;
        cmd_addr    = BASE_ADDR + SR_OFS;
        if (cmd_ready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (rsp_valid) begin
          if (rsp_err) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if ((rsp_data & SR_IDLE_MASK) == SR_IDLE_VAL) begin
            err_d   = 1'b0;
            state_d = ST_DONE;
          end else if (poll_next >= POLL_MAX) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            poll_cnt_d = PC_W'(poll_next);
            gap_cnt_d  = '0;
            state_d    = ST_GAP;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_iic_axil_sequencer.sv
// Bench for iic_axil_sequencer: AXI-Lite slave model with tunable AW backpressure, B error
// injection and scripted SR values; a monitor scores writes and completions against queues.
`timescale 1ns/1ps
module tb_iic_axil_sequencer;

  localparam logic [31:0] BASE = 32'h43C0_0000;
  localparam int unsigned PMAX = 4;
  localparam int unsigned PGAP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [6:0]  req_dev_addr = '0;
  logic [7:0]  req_data = '0;
  logic        done_valid, done_err;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  always #5 clk = ~clk;

  iic_axil_sequencer #(.BASE_ADDR(BASE), .POLL_MAX(PMAX), .POLL_GAP(PGAP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dev_addr(req_dev_addr), .req_data(req_data),
    .done_valid(done_valid), .done_err(done_err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model
  int          aw_delay = 0;
  int          aw_wait = 0;
  int          sl_b_cnt = 0;
  int          err_b_idx = -1;
  logic        aw_got = 1'b0, w_got = 1'b0;
  logic        bvalid_r = 1'b0, rvalid_r = 1'b0;
  logic [1:0]  bresp_r = 2'b00;
  logic [31:0] rdata_r = '0;
  logic [31:0] sr_vals[$];

  assign m_awready = m_awvalid && (aw_wait >= aw_delay);
  assign m_wready  = 1'b1;
  assign m_arready = 1'b1;
  assign m_bvalid  = bvalid_r;
  assign m_bresp   = bresp_r;
  assign m_rvalid  = rvalid_r;
  assign m_rdata   = rdata_r;
  assign m_rresp   = 2'b00;

  always @(posedge clk) begin
    if (rst) begin
      aw_wait  <= 0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      bvalid_r <= 1'b0;
      bresp_r  <= 2'b00;
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
    end else begin
      if (m_awvalid && !m_awready) aw_wait <= aw_wait + 1;
      else aw_wait <= 0;
      if ((aw_got || (m_awvalid && m_awready)) && (w_got || (m_wvalid && m_wready)) && !bvalid_r) begin
        bvalid_r <= 1'b1;
        bresp_r  <= (sl_b_cnt == err_b_idx) ? 2'b10 : 2'b00;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end else begin
        if (m_awvalid && m_awready) aw_got <= 1'b1;
        if (m_wvalid && m_wready) w_got <= 1'b1;
      end
      if (bvalid_r && m_bready) begin
        bvalid_r <= 1'b0;
        sl_b_cnt <= sl_b_cnt + 1;
      end
      if (m_arvalid && m_arready) begin
        rvalid_r <= 1'b1;
        rdata_r  <= sr_vals[0];
        if (sr_vals.size() > 1) void'(sr_vals.pop_front());
      end
      if (rvalid_r && m_rready) rvalid_r <= 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues and monitor
  logic [31:0] exp_wr_addr[$], exp_wr_data[$];
  logic        exp_done[$];
  logic [31:0] aw_q[$], w_q[$];
  int aw_hs_cnt = 0, b_hs_cnt = 0, ar_hs_cnt = 0, done_cnt = 0, unstable_cnt = 0;
  int aw_run = 0, w_run = 0;
  int aw_run_log[$], w_run_log[$], ar_cyc_log[$], r_cyc_log[$];
  logic [31:0] aw_hold, w_hold;

  initial begin
    logic [31:0] a, d;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_q.delete();
        w_q.delete();
        aw_run = 0;
        w_run = 0;
      end else begin
        if (m_awvalid) begin
          if (aw_run == 0) aw_hold = m_awaddr;
          else if (m_awaddr !== aw_hold) unstable_cnt++;
          aw_run++;
          if (m_awready) begin
            aw_q.push_back(m_awaddr);
            aw_run_log.push_back(aw_run);
            aw_run = 0;
            aw_hs_cnt++;
          end
        end
        if (m_wvalid) begin
          if (w_run == 0) w_hold = m_wdata;
          else if (m_wdata !== w_hold) unstable_cnt++;
          w_run++;
          if (m_wready) begin
            w_q.push_back(m_wdata);
            w_run_log.push_back(w_run);
            w_run = 0;
          end
        end
        if (m_bvalid && m_bready) b_hs_cnt++;
        if (m_arvalid && m_arready) begin
          ar_hs_cnt++;
          ar_cyc_log.push_back(cyc);
        end
        if (m_rvalid && m_rready) r_cyc_log.push_back(cyc);
        if (aw_q.size() > 0 && w_q.size() > 0) begin
          a = aw_q.pop_front();
          d = w_q.pop_front();
          if (exp_wr_addr.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", a, d);
          end else begin
            check("wr_addr", a, exp_wr_addr.pop_front());
            check("wr_data", d, exp_wr_data.pop_front());
          end
        end
        if (done_valid) begin
          done_cnt++;
          if (exp_done.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: got done_err=%0d, expected no completion", done_err);
          end else begin
            check("done_err", {31'd0, done_err}, {31'd0, exp_done.pop_front()});
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    exp_wr_addr.push_back(a);
    exp_wr_data.push_back(d);
  endtask

  task automatic push_seq(input logic [31:0] fifo_a, input logic [31:0] fifo_d);
    push_wr(32'h43C0_0100, 32'h0000_0002);
    push_wr(32'h43C0_0100, 32'h0000_0001);
    push_wr(32'h43C0_0108, fifo_a);
    push_wr(32'h43C0_0108, fifo_d);
  endtask

  task automatic issue(input logic [6:0] dev, input logic [7:0] data);
    int guard = 0;
    while (!req_ready && guard < 200) begin
      tick();
      guard++;
    end
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_dev_addr = dev;
    req_data     = data;
    req_valid    = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int start_cnt, input string name);
    int guard = 0;
    while (done_cnt == start_cnt && guard < 3000) begin
      tick();
      guard++;
    end
    if (done_cnt == start_cnt) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got no done_valid within 3000 cycles, expected one", name);
    end
    tick(4);
  endtask

  initial begin
    int ar0, b0, d0, aw0, guard;

    rst = 1'b1;
    tick(3);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valids", {25'd0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, done_valid, done_err}, 32'd0);
    check("rst_addr_data", m_awaddr | m_araddr | m_wdata, 32'd0);
    rst = 1'b0;
    tick(2);

    // Basic: dev 0x50, data 0xA5
    aw_delay = 0;
    sr_vals = '{32'h80};
    push_seq(32'h0000_01A0, 32'h0000_02A5);
    exp_done.push_back(1'b0);
    ar0 = ar_hs_cnt; b0 = b_hs_cnt; d0 = done_cnt;
    issue(7'h50, 8'hA5);
    tick();
    req_valid = 1'b1; req_dev_addr = 7'h11; req_data = 8'h11;
    for (int i = 0; i < 3; i++) begin
      check("req_ready_busy", {31'd0, req_ready}, 32'd0);
      tick();
    end
    req_valid = 1'b0;
    wait_done(d0, "basic_done");
    check("basic_ar_count", ar_hs_cnt - ar0, 1);
    check("basic_b_count", b_hs_cnt - b0, 4);

    // AW backpressure: awready 3 cycles late, wready immediate
    aw_delay = 3;
    sr_vals = '{32'h80};
    aw_run_log.delete(); w_run_log.delete();
    push_seq(32'h0000_0178, 32'h0000_025A);
    exp_done.push_back(1'b0);
    b0 = b_hs_cnt; d0 = done_cnt;
    issue(7'h3C, 8'h5A);
    wait_done(d0, "bp_done");
    check("bp_b_count", b_hs_cnt - b0, 4);
    check("bp_aw_beats", aw_run_log.size(), 4);
    foreach (aw_run_log[i]) check("bp_aw_hold", aw_run_log[i], 4);
    foreach (w_run_log[i]) check("bp_w_hold", w_run_log[i], 1);
    check("bp_stable", unstable_cnt, 0);

    // Polling: busy twice, then idle
    aw_delay = 0;
    sr_vals = '{32'h84, 32'h84, 32'h80};
    ar_cyc_log.delete(); r_cyc_log.delete();
    push_seq(32'h0000_01FE, 32'h0000_02FF);
    exp_done.push_back(1'b0);
    d0 = done_cnt;
    issue(7'h7F, 8'hFF);
    wait_done(d0, "poll_done");
    check("poll_ar_count", ar_cyc_log.size(), 3);
    for (int i = 1; i < 3; i++) begin
      if (ar_cyc_log.size() > i && r_cyc_log.size() >= i)
        check("poll_spacing", {31'd0, (ar_cyc_log[i] - r_cyc_log[i-1]) >= int'(PGAP) + 1}, 32'd1);
    end

    // Write error on step 1
    sr_vals = '{32'h80};
    err_b_idx = sl_b_cnt + 1;
    push_wr(32'h43C0_0100, 32'h0000_0002);
    push_wr(32'h43C0_0100, 32'h0000_0001);
    exp_done.push_back(1'b1);
    aw0 = aw_hs_cnt; ar0 = ar_hs_cnt; d0 = done_cnt;
    issue(7'h01, 8'h00);
    wait_done(d0, "err_done");
    tick(20);
    check("err_aw_count", aw_hs_cnt - aw0, 2);
    check("err_ar_count", ar_hs_cnt - ar0, 0);
    err_b_idx = -1;

    // Poll timeout: bus never idles
    sr_vals = '{32'h04};
    push_seq(32'h0000_0144, 32'h0000_0281);
    exp_done.push_back(1'b1);
    ar0 = ar_hs_cnt; d0 = done_cnt;
    issue(7'h22, 8'h81);
    wait_done(d0, "timeout_done");
    check("timeout_ar_count", ar_hs_cnt - ar0, 4);

    // Reset while step 2 has AW pending
    aw_delay = 3;
    sr_vals = '{32'h80};
    push_seq(32'h0000_012A, 32'h0000_023C);
    b0 = b_hs_cnt; d0 = done_cnt;
    issue(7'h15, 8'h3C);
    guard = 0;
    while (!(m_awvalid && (b_hs_cnt - b0 == 2)) && guard < 500) begin
      tick();
      guard++;
    end
    check("midrst_at_step2", {31'd0, m_awvalid && (b_hs_cnt - b0 == 2)}, 32'd1);
    rst = 1'b1;
    exp_wr_addr.delete();
    exp_wr_data.delete();
    tick();
    check("midrst_aw_w", {30'd0, m_awvalid, m_wvalid}, 32'd0);
    check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    rst = 1'b0;
    tick(10);
    check("midrst_no_done", done_cnt - d0, 0);

    aw_delay = 0;
    sr_vals = '{32'h80};
    push_seq(32'h0000_012A, 32'h0000_023C);
    exp_done.push_back(1'b0);
    d0 = done_cnt;
    issue(7'h15, 8'h3C);
    wait_done(d0, "post_rst_done");

    check("exp_writes_drained", exp_wr_addr.size(), 0);
    check("exp_done_drained", exp_done.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
